// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and constants for the restoring divider.
package div_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [63:0] DZ_QUOT = '1;
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one shift / trial-subtract / restore step on a WIDTH+1-bit partial remainder.
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  always_comb begin
    shifted = {rem_i[WIDTH-1:0], bit_i};
    diff = shifted - {1'b0, divisor_i};
    q_o = ~diff[WIDTH];
    rem_o = q_o ? diff : shifted;
  end
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per CALC cycle.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, step_rem;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, qacc_q, qacc_d, step_quo;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic dbz_q, dbz_d, step_q;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign step_quo = (qacc_q << 1) | WIDTH'(step_q);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    qacc_d = qacc_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = divisor == '0 ? FINISH : CALC;
        cnt_d = '0;
        rem_d = '0;
        dvd_d = dividend;
        dvs_d = divisor;
        qacc_d = '0;
        if (divisor == '0) begin
          quo_d = DZ_QUOT[WIDTH-1:0];
          rmd_d = dividend;
          dbz_d = 1'b1;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        rem_d = step_rem;
        dvd_d = dvd_q << 1;
        qacc_d = step_quo;
        // the last step's result goes straight to the outputs as FINISH is entered
        if (cnt_q == LAST) begin
          state_d = FINISH;
          quo_d = step_quo;
          rmd_d = step_rem[WIDTH-1:0];
          dbz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      qacc_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      qacc_q <= qacc_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dbz_q <= dbz_d;
    end
  end

  assign busy = state_q == CALC;
  assign done = state_q == FINISH;
  assign quotient = quo_q;
  assign remainder = rmd_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and random checks of the divider against integer division.
module tb_restoring_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic [7:0] quotient, remainder;
  logic busy, done, div_by_zero;
  int errors = 0;
  int checks = 0;

  restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at the negedge of the following idle cycle
  task automatic do_div(input logic [7:0] a, input logic [7:0] b);
    int last;
    logic [7:0] eq, er;
    eq = (b == 0) ? 8'd255 : 8'(a / b);
    er = (b == 0) ? a : 8'(a % b);
    last = (b == 0) ? 1 : 9;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = ~a;
    divisor = ~b;
    for (int c = 1; c <= last; c++) begin
      chk("busy", busy, (b != 0 && c <= 8) ? 1 : 0);
      chk("done", done, (c == last) ? 1 : 0);
      if (c < last) @(negedge clk);
    end
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_quotient", quotient, eq);
    chk("hold_remainder", remainder, er);
  endtask

  initial begin
    int ndone;
    logic [7:0] a, b;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_div(8'd200, 8'd7);
    do_div(8'd255, 8'd1);
    do_div(8'd5, 8'd9);
    do_div(8'd255, 8'd255);
    do_div(8'd37, 8'd0);
    // start during CALC must be ignored
    dividend = 8'd100;
    divisor = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 4) begin
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd5;
      end
      if (c == 5) start = 1'b0;
      if (done) begin
        ndone++;
        chk("ign_done_cycle", c, 9);
        chk("ign_quotient", quotient, 33);
        chk("ign_remainder", remainder, 1);
      end
      @(negedge clk);
    end
    chk("ign_done_count", ndone, 1);
    // async reset in the middle of CALC
    dividend = 8'd200;
    divisor = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", ndone, 0);
    do_div(8'd9, 8'd2);
    // start held high: back-to-back operations with one idle cycle between
    dividend = 8'd200;
    divisor = 8'd7;
    start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 19) start = 1'b0;
      chk("b2b_done", done, (c == 9 || c == 19) ? 1 : 0);
      chk("b2b_busy", busy, ((c >= 1 && c <= 8) || (c >= 11 && c <= 18)) ? 1 : 0);
    end
    @(negedge clk);
    chk("b2b_quotient", quotient, 28);
    // corner operands
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 5; j++) begin
        a = (i == 0) ? 8'd0 : (i == 1) ? 8'd1 : (i == 2) ? 8'd128 : 8'd255;
        b = (j == 0) ? 8'd0 : (j == 1) ? 8'd1 : (j == 2) ? 8'd2 : (j == 3) ? 8'd128 : 8'd255;
        do_div(a, b);
      end
    // random sweep
    for (int n = 0; n < 3000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      do_div(a, b);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
